// File: rtl/core_pkg.sv
// Shared core definitions: FSM encodings, opcodes, control-bit indices.
package core_pkg;

  localparam int unsigned STATE_W     = 2;
  localparam int unsigned REG_W       = 5;
  localparam int unsigned FLUSH_CNT_W = 3;
  localparam int unsigned WAIT_CNT_W  = 8;
  localparam int unsigned OPCODE_W    = 7;

  // Sequencer FSM encodings (visible on state_o)
  localparam logic [STATE_W-1:0] STATE_RUN      = 2'd0;
  localparam logic [STATE_W-1:0] STATE_FLUSH    = 2'd1;
  localparam logic [STATE_W-1:0] STATE_MEM_WAIT = 2'd2;

  // RV32I major opcodes
  localparam logic [OPCODE_W-1:0] OP_LOAD   = 7'b0000011;
  localparam logic [OPCODE_W-1:0] OP_STORE  = 7'b0100011;
  localparam logic [OPCODE_W-1:0] OP_BRANCH = 7'b1100011;
  localparam logic [OPCODE_W-1:0] OP_JAL    = 7'b1101111;
  localparam logic [OPCODE_W-1:0] OP_JALR   = 7'b1100111;
  localparam logic [OPCODE_W-1:0] OP_OP     = 7'b0110011;
  localparam logic [OPCODE_W-1:0] OP_OP_IMM = 7'b0010011;
  localparam logic [OPCODE_W-1:0] OP_LUI    = 7'b0110111;
  localparam logic [OPCODE_W-1:0] OP_AUIPC  = 7'b0010111;

  // Bit positions in the decoded control word carried down the pipe
  localparam int unsigned CTRL_W        = 6;
  localparam int unsigned CTRL_USES_RS1 = 0;
  localparam int unsigned CTRL_USES_RS2 = 1;
  localparam int unsigned CTRL_MEM_REN  = 2;
  localparam int unsigned CTRL_MEM_WEN  = 3;
  localparam int unsigned CTRL_BRANCH   = 4;
  localparam int unsigned CTRL_REG_WEN  = 5;

  // Decoder used by the core so uses_rs*/mem_ren agree with this unit
  function automatic logic [CTRL_W-1:0] decode_ctrl(input logic [OPCODE_W-1:0] opcode);
    logic [CTRL_W-1:0] c;
    c = '0;
    case (opcode)
      OP_LOAD:   begin c[CTRL_USES_RS1] = 1'b1; c[CTRL_MEM_REN] = 1'b1; c[CTRL_REG_WEN] = 1'b1; end
      OP_STORE:  begin c[CTRL_USES_RS1] = 1'b1; c[CTRL_USES_RS2] = 1'b1; c[CTRL_MEM_WEN] = 1'b1; end
      OP_BRANCH: begin c[CTRL_USES_RS1] = 1'b1; c[CTRL_USES_RS2] = 1'b1; c[CTRL_BRANCH] = 1'b1; end
      OP_OP:     begin c[CTRL_USES_RS1] = 1'b1; c[CTRL_USES_RS2] = 1'b1; c[CTRL_REG_WEN] = 1'b1; end
      OP_OP_IMM,
      OP_JALR:   begin c[CTRL_USES_RS1] = 1'b1; c[CTRL_REG_WEN] = 1'b1; end
      OP_JAL,
      OP_LUI,
      OP_AUIPC:  c[CTRL_REG_WEN] = 1'b1;
      default:   c = '0;
    endcase
    return c;
  endfunction

  // Load in q3 writes a register that the q2 instruction reads (x0 never hazards)
  function automatic logic load_use_hit(
    input logic             mem_ren,
    input logic [REG_W-1:0] rd,
    input logic             uses_rs1,
    input logic [REG_W-1:0] rs1,
    input logic             uses_rs2,
    input logic [REG_W-1:0] rs2
  );
    return mem_ren && (rd != '0) &&
           ((uses_rs1 && (rs1 == rd)) || (uses_rs2 && (rs2 == rd)));
  endfunction

endpackage

// File: rtl/sat_counter.sv
// Saturating up-counter.
// Ports: clk, rst_n (async active-low), i_en (count this cycle), o_count.
module sat_counter #(
  parameter int unsigned W = 16
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         i_en,
  output logic [W-1:0] o_count
);

  logic [W-1:0] r_count;

  // Holds at all-ones once reached
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_count <= '0;
    end else if (i_en && (r_count != {W{1'b1}})) begin
      r_count <= r_count + W'(1);
    end
  end

  assign o_count = r_count;

endmodule

// File: rtl/pipe_hazard_ctrl.sv
// Pipeline sequencer for the 5-stage core: load-use bubble, taken-branch
// squash, data-memory freeze with timeout, and performance counters.
// Inputs : q2 source regs/uses, q3 rd/load, dmem_req/ready, branch_taken_q4.
// Outputs: stage enables, q2q3 bubble, stage flushes, pc_sel_branch (all
//          combinational from state + inputs), err_timeout, stall_cycles,
//          flush_events, state_o (registered).
module pipe_hazard_ctrl
  import core_pkg::*;
#(
  parameter int unsigned FLUSH_CYCLES = 1,
  parameter int unsigned MEM_TIMEOUT  = 15,
  parameter int unsigned CNT_W        = 16
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic [4:0]       rs1_q2,
  input  logic [4:0]       rs2_q2,
  input  logic             uses_rs1_q2,
  input  logic             uses_rs2_q2,
  input  logic [4:0]       rd_q3,
  input  logic             mem_ren_q3,
  input  logic             dmem_req,
  input  logic             dmem_ready,
  input  logic             branch_taken_q4,
  output logic             pc_en,
  output logic             q1q2_en,
  output logic             q2q3_en,
  output logic             q3q4_en,
  output logic             q4q5_en,
  output logic             q2q3_bubble,
  output logic             q1q2_flush,
  output logic             q2q3_flush,
  output logic             q3q4_flush,
  output logic             pc_sel_branch,
  output logic             err_timeout,
  output logic [CNT_W-1:0] stall_cycles,
  output logic [CNT_W-1:0] flush_events,
  output logic [1:0]       state_o
);

  localparam int unsigned LIMIT_W = WAIT_CNT_W + 1;

  logic [STATE_W-1:0]     r_state,     w_state_nxt;
  logic [FLUSH_CNT_W-1:0] r_flush_cnt, w_flush_cnt_nxt;
  logic [WAIT_CNT_W-1:0]  r_wait_cnt,  w_wait_cnt_nxt;
  logic                   r_err,       w_err_nxt;

  logic w_load_use;
  logic w_wait_limit;
  logic w_freeze;
  logic w_load_stall;
  logic w_flush_inc;

  assign w_load_use = load_use_hit(mem_ren_q3, rd_q3, uses_rs1_q2, rs1_q2,
                                   uses_rs2_q2, rs2_q2);

  // r_wait_cnt counts wait cycles already spent; this cycle is the next one
  assign w_wait_limit = (LIMIT_W'(r_wait_cnt) + LIMIT_W'(1)) >= LIMIT_W'(MEM_TIMEOUT);

  // State register
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state     <= STATE_RUN;
      r_flush_cnt <= '0;
      r_wait_cnt  <= '0;
      r_err       <= 1'b0;
    end else begin
      r_state     <= w_state_nxt;
      r_flush_cnt <= w_flush_cnt_nxt;
      r_wait_cnt  <= w_wait_cnt_nxt;
      r_err       <= w_err_nxt;
    end
  end

  // Next-state and sequencing decisions
  always_comb begin
    w_state_nxt     = r_state;
    w_flush_cnt_nxt = r_flush_cnt;
    w_wait_cnt_nxt  = r_wait_cnt;
    w_err_nxt       = r_err;
    w_freeze        = 1'b0;
    w_load_stall    = 1'b0;
    w_flush_inc     = 1'b0;
    pc_sel_branch   = 1'b0;
    q1q2_flush      = 1'b0;
    q2q3_flush      = 1'b0;
    q3q4_flush      = 1'b0;

    case (r_state)
      STATE_RUN: begin
        if (branch_taken_q4) begin
          // q2 and q3 are squashed, so their hazards are irrelevant
          pc_sel_branch = 1'b1;
          q1q2_flush    = 1'b1;
          q2q3_flush    = 1'b1;
          q3q4_flush    = 1'b1;
          w_flush_inc   = 1'b1;
          if (FLUSH_CYCLES > 0) begin
            w_state_nxt     = STATE_FLUSH;
            w_flush_cnt_nxt = FLUSH_CNT_W'(FLUSH_CYCLES);
          end
        end else if (dmem_req && !dmem_ready) begin
          w_freeze       = 1'b1;
          w_state_nxt    = STATE_MEM_WAIT;
          w_wait_cnt_nxt = WAIT_CNT_W'(1);
        end else if (w_load_use) begin
          w_load_stall = 1'b1;
        end
      end

      STATE_FLUSH: begin
        // Drops the stale fetch still arriving from synchronous imem
        q1q2_flush = 1'b1;
        if (r_flush_cnt <= FLUSH_CNT_W'(1)) begin
          w_state_nxt = STATE_RUN;
        end else begin
          w_flush_cnt_nxt = r_flush_cnt - FLUSH_CNT_W'(1);
        end
      end

      STATE_MEM_WAIT: begin
        if (dmem_ready) begin
          w_state_nxt = STATE_RUN;
        end else if (w_wait_limit) begin
          w_err_nxt   = 1'b1;
          w_state_nxt = STATE_RUN;
        end else begin
          w_freeze       = 1'b1;
          w_wait_cnt_nxt = r_wait_cnt + WAIT_CNT_W'(1);
        end
      end

      default: w_state_nxt = STATE_RUN;
    endcase
  end

  // Stage enables: freeze holds everything, load-use holds only PC and q1q2
  assign pc_en       = !(w_freeze || w_load_stall);
  assign q1q2_en     = !(w_freeze || w_load_stall);
  assign q2q3_en     = !w_freeze;
  assign q3q4_en     = !w_freeze;
  assign q4q5_en     = !w_freeze;
  assign q2q3_bubble = w_load_stall;
  assign err_timeout = r_err;
  assign state_o     = r_state;

  sat_counter #(.W(CNT_W)) u_stall_cnt (
    .clk     (clk),
    .rst_n   (rst_n),
    .i_en    (!pc_en),
    .o_count (stall_cycles)
  );

  sat_counter #(.W(CNT_W)) u_flush_cnt (
    .clk     (clk),
    .rst_n   (rst_n),
    .i_en    (w_flush_inc),
    .o_count (flush_events)
  );

endmodule

// File: tb/tb_pipe_hazard_ctrl.sv
// Scoreboard bench for pipe_hazard_ctrl: directed scenarios then random traffic.
module tb_pipe_hazard_ctrl;

  localparam int unsigned FC  = 1;
  localparam int unsigned MT  = 15;
  localparam int unsigned CW  = 4;
  localparam int          CMAX = (1 << CW) - 1;

  logic          clk = 1'b0;
  logic          rst_n = 1'b0;
  logic [4:0]    rs1_q2, rs2_q2, rd_q3;
  logic          uses_rs1_q2, uses_rs2_q2, mem_ren_q3;
  logic          dmem_req, dmem_ready, branch_taken_q4;
  logic          pc_en, q1q2_en, q2q3_en, q3q4_en, q4q5_en, q2q3_bubble;
  logic          q1q2_flush, q2q3_flush, q3q4_flush, pc_sel_branch, err_timeout;
  logic [CW-1:0] stall_cycles, flush_events;
  logic [1:0]    state_o;

  always #5 clk = ~clk;

  pipe_hazard_ctrl #(.FLUSH_CYCLES(FC), .MEM_TIMEOUT(MT), .CNT_W(CW)) dut (
    .clk(clk), .rst_n(rst_n),
    .rs1_q2(rs1_q2), .rs2_q2(rs2_q2), .uses_rs1_q2(uses_rs1_q2), .uses_rs2_q2(uses_rs2_q2),
    .rd_q3(rd_q3), .mem_ren_q3(mem_ren_q3), .dmem_req(dmem_req), .dmem_ready(dmem_ready),
    .branch_taken_q4(branch_taken_q4),
    .pc_en(pc_en), .q1q2_en(q1q2_en), .q2q3_en(q2q3_en), .q3q4_en(q3q4_en), .q4q5_en(q4q5_en),
    .q2q3_bubble(q2q3_bubble), .q1q2_flush(q1q2_flush), .q2q3_flush(q2q3_flush),
    .q3q4_flush(q3q4_flush), .pc_sel_branch(pc_sel_branch), .err_timeout(err_timeout),
    .stall_cycles(stall_cycles), .flush_events(flush_events), .state_o(state_o)
  );

  typedef struct packed {
    logic [4:0] rs1, rs2, rd;
    logic u1, u2, mren, req, rdy, br;
  } stim_t;

  typedef struct packed {
    logic pc_en, q1q2_en, q2q3_en, q3q4_en, q4q5_en, bubble;
    logic f12, f23, f34, pcsel, err;
    logic [1:0] st;
  } ctrl_t;

  typedef struct {
    ctrl_t c;
    int    stall;
    int    flush;
    int    cyc;
  } exp_t;

  exp_t sb[$];
  int   n_cmp = 0;
  int   n_bad = 0;
  int   cyc   = 0;

  // Reference model: mode 0 running, 1 flushing, 2 waiting on memory
  int m_mode, m_flush_left, m_waited, m_stalls, m_flushes;
  bit m_err;

  task automatic model_reset();
    m_mode = 0; m_flush_left = 0; m_waited = 0;
    m_stalls = 0; m_flushes = 0; m_err = 1'b0;
  endtask

  task automatic model_step(input stim_t s, output exp_t e);
    bit hit;
    e.c = '0;
    {e.c.pc_en, e.c.q1q2_en, e.c.q2q3_en, e.c.q3q4_en, e.c.q4q5_en} = 5'b11111;
    e.c.err = m_err;
    e.c.st  = 2'(m_mode);
    e.stall = m_stalls;
    e.flush = m_flushes;
    e.cyc   = cyc;
    hit = s.mren && (s.rd != 0) && ((s.u1 && s.rs1 == s.rd) || (s.u2 && s.rs2 == s.rd));
    if (m_mode == 0) begin
      if (s.br) begin
        e.c.pcsel = 1; e.c.f12 = 1; e.c.f23 = 1; e.c.f34 = 1;
        if (m_flushes < CMAX) m_flushes++;
        if (FC > 0) begin m_mode = 1; m_flush_left = FC; end
      end else if (s.req && !s.rdy) begin
        {e.c.pc_en, e.c.q1q2_en, e.c.q2q3_en, e.c.q3q4_en, e.c.q4q5_en} = 5'b00000;
        m_mode = 2; m_waited = 1;
      end else if (hit) begin
        e.c.pc_en = 0; e.c.q1q2_en = 0; e.c.bubble = 1;
      end
    end else if (m_mode == 1) begin
      e.c.f12 = 1;
      m_flush_left--;
      if (m_flush_left == 0) m_mode = 0;
    end else begin
      if (s.rdy) begin
        m_mode = 0;
      end else if (m_waited + 1 >= MT) begin
        m_err = 1; m_mode = 0;
      end else begin
        {e.c.pc_en, e.c.q1q2_en, e.c.q2q3_en, e.c.q3q4_en, e.c.q4q5_en} = 5'b00000;
        m_waited++;
      end
    end
    if (!e.c.pc_en && m_stalls < CMAX) m_stalls++;
  endtask

  task automatic drive(input stim_t s);
    rs1_q2 = s.rs1; rs2_q2 = s.rs2; rd_q3 = s.rd;
    uses_rs1_q2 = s.u1; uses_rs2_q2 = s.u2; mem_ren_q3 = s.mren;
    dmem_req = s.req; dmem_ready = s.rdy; branch_taken_q4 = s.br;
  endtask

  task automatic apply(input stim_t s);
    exp_t e;
    @(posedge clk); #1;
    cyc++;
    drive(s);
    model_step(s, e);
    sb.push_back(e);
  endtask

  // Asynchronous reset asserted mid-cycle, released after the sample point
  task automatic do_reset();
    exp_t e;
    @(posedge clk); #1;
    cyc++;
    drive('0);
    rst_n = 1'b0;
    model_reset();
    e.c = '0;
    {e.c.pc_en, e.c.q1q2_en, e.c.q2q3_en, e.c.q3q4_en, e.c.q4q5_en} = 5'b11111;
    e.stall = 0; e.flush = 0; e.cyc = cyc;
    sb.push_back(e);
    @(negedge clk); #1;
    rst_n = 1'b1;
  endtask

  function automatic stim_t mk_hit(input logic [4:0] r);
    stim_t s = '0;
    s.mren = 1; s.rd = r; s.rs1 = r; s.u1 = 1;
    return s;
  endfunction

  function automatic stim_t mk_wait(input logic rdy);
    stim_t s = '0;
    s.req = 1; s.rdy = rdy;
    return s;
  endfunction

  function automatic stim_t mk_branch();
    stim_t s = '0;
    s.br = 1;
    return s;
  endfunction

  function automatic stim_t mk_random();
    stim_t s;
    s.rs1  = 5'($urandom_range(0, 3));
    s.rs2  = 5'($urandom_range(0, 3));
    s.rd   = 5'($urandom_range(0, 3));
    s.u1   = 1'($urandom_range(0, 1));
    s.u2   = 1'($urandom_range(0, 1));
    s.mren = 1'($urandom_range(0, 1));
    s.req  = ($urandom_range(0, 3) == 0);
    s.rdy  = ($urandom_range(0, 2) == 0);
    // a second taken branch while flushing is outside the protocol
    s.br   = (m_mode != 1) && ($urandom_range(0, 9) == 0);
    return s;
  endfunction

  // Monitor: one expectation per cycle, sampled on the falling edge
  always @(negedge clk) begin
    exp_t  e;
    ctrl_t a;
    if (sb.size() > 0) begin
      e = sb.pop_front();
      a = '{pc_en: pc_en, q1q2_en: q1q2_en, q2q3_en: q2q3_en, q3q4_en: q3q4_en,
            q4q5_en: q4q5_en, bubble: q2q3_bubble, f12: q1q2_flush, f23: q2q3_flush,
            f34: q3q4_flush, pcsel: pc_sel_branch, err: err_timeout, st: state_o};
      n_cmp++;
      if (a !== e.c) begin
        n_bad++;
        $display("FAIL ctrl cyc %0d: got %b expected %b (pc,q12,q23,q34,q45,bub,f12,f23,f34,sel,err,st)",
                 e.cyc, a, e.c);
      end
      n_cmp++;
      if (stall_cycles !== CW'(e.stall) || flush_events !== CW'(e.flush)) begin
        n_bad++;
        $display("FAIL counters cyc %0d: got stall=%0d flush=%0d expected stall=%0d flush=%0d",
                 e.cyc, stall_cycles, flush_events, e.stall, e.flush);
      end
    end
  end

  initial begin
    stim_t s;
    drive('0);
    model_reset();
    do_reset();

    // load-use stall for one cycle, then normal flow
    apply(mk_hit(5'd1));
    apply('0);
    // x0 destination and unused rs2 never stall
    s = '0; s.mren = 1; s.rd = 0; s.rs1 = 0; s.u1 = 1; apply(s);
    s = '0; s.mren = 1; s.rd = 5'd3; s.rs2 = 5'd3; s.u2 = 0; apply(s);
    s = '0; s.mren = 1; s.rd = 5'd7; s.rs2 = 5'd7; s.u2 = 1; apply(s);
    apply('0);

    // taken branch and its flush window
    apply(mk_branch());
    apply('0);
    apply('0);

    // three memory-wait cycles then ready
    repeat (3) apply(mk_wait(1'b0));
    apply(mk_wait(1'b1));
    apply('0);

    // memory never ready: forced release and sticky error
    do_reset();
    repeat (16) apply(mk_wait(1'b0));
    repeat (3) apply('0);
    do_reset();
    apply('0);

    // branch beats memory wait and load-use; then reset mid-flush
    s = mk_hit(5'd2); s.req = 1; s.rdy = 0; s.br = 1;
    apply(s);
    do_reset();
    apply('0);

    // counter saturation
    repeat (CMAX + 3) apply(mk_hit(5'd4));
    repeat (CMAX + 3) begin apply(mk_branch()); apply('0); end
    apply('0);

    // random traffic with occasional resets
    do_reset();
    for (int i = 0; i < 1500; i++) begin
      if ($urandom_range(0, 249) == 0) do_reset();
      else apply(mk_random());
    end

    @(negedge clk); #1;
    n_cmp++;
    if (sb.size() != 0) begin
      n_bad++;
      $display("FAIL drain: %0d expectations left, expected 0", sb.size());
    end
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule

// File: doc/pipe_hazard_ctrl.md
Name: pipe_hazard_ctrl

Overview:
Pipeline sequencing unit for the 5-stage core (q1 fetch, q2 decode, q3 execute, q4 memory, q5 writeback).
- Detects load-use hazards and inserts one bubble.
- Squashes younger stages when a branch resolves taken in q4.
- Freezes the whole pipeline while data memory is not ready.
- Drives every pipeline-register enable and flush, the PC select, and saturating performance counters.
- Sits beside the forwarding unit; forwarding resolves every other data hazard.

Parameters:
FLUSH_CYCLES, 1, extra cycles q1q2 flush is held after a taken branch (covers synchronous instruction memory latency); legal 0..7
MEM_TIMEOUT, 15, maximum consecutive memory-wait cycles before forced release; legal 1..255
CNT_W, 16, width of performance counters

Ports:
clk  in  1  clock
rst_n  in  1  reset, asynchronous, active-low
rs1_q2  in  5  rs1 of instruction in q2
rs2_q2  in  5  rs2 of instruction in q2
uses_rs1_q2  in  1  q2 instruction reads rs1
uses_rs2_q2  in  1  q2 instruction reads rs2 (R-type, store, branch)
rd_q3  in  5  destination of instruction in q3
mem_ren_q3  in  1  q3 instruction is a load
dmem_req  in  1  q3 issues data memory access (ren or wren)
dmem_ready  in  1  data memory accepts/returns this cycle
branch_taken_q4  in  1  branch in q4 resolved taken
pc_en  out  1  PC register update enable
q1q2_en  out  1  q1q2 load enable
q2q3_en  out  1  q2q3 load enable
q3q4_en  out  1  q3q4 load enable
q4q5_en  out  1  q4q5 load enable
q2q3_bubble  out  1  load zero ctrl into q2q3 (NOP)
q1q2_flush  out  1  clear q1q2 at next edge
q2q3_flush  out  1  clear q2q3 at next edge
q3q4_flush  out  1  clear q3q4 at next edge
pc_sel_branch  out  1  PC mux selects branch target
err_timeout  out  1  sticky memory-wait timeout flag
stall_cycles  out  CNT_W  cycles with pc_en=0, saturating
flush_events  out  CNT_W  accepted taken branches, saturating
state_o  out  2  FSM state (RUN=0, FLUSH=1, MEM_WAIT=2)

Behaviour:
- Registered state: FSM, flush down-counter (3 bit), wait counter (8 bit), err_timeout, both counters.
- Reset values: state RUN, all counters 0, err_timeout 0.
- All other outputs are combinational from state and inputs. In RUN with idle inputs: all enables 1; bubble, flushes and pc_sel_branch 0.
- Priority in RUN: branch > memory wait > load-use.
- Branch (RUN, branch_taken_q4=1):
  - pc_sel_branch=1; q1q2/q2q3/q3q4 flush=1; all enables 1.
  - dmem_req and load-use ignored this cycle (q3 and q2 are squashed).
  - flush_events++.
  - If FLUSH_CYCLES>0: go to FLUSH with counter=FLUSH_CYCLES; else stay in RUN.
- FLUSH:
  - q1q2_flush=1; enables 1; load-use and dmem_req ignored.
  - Counter decrements; at 1 go to RUN.
  - A further branch_taken_q4 in FLUSH is a protocol violation; behaviour is undefined.
- Memory wait (RUN, dmem_req=1, dmem_ready=0, no branch):
  - All five enables 0 in that same cycle; go to MEM_WAIT with wait counter=1.
- MEM_WAIT:
  - All enables 0 while dmem_ready=0; wait counter increments.
  - dmem_ready=1: enables 1 that cycle; return to RUN.
  - If wait counter reaches MEM_TIMEOUT with dmem_ready still 0: set err_timeout (cleared only by reset), enables 1 that cycle, return to RUN.
- Load-use (RUN, no branch, no wait): condition is mem_ren_q3 && rd_q3!=0 && ((uses_rs1_q2 && rs1_q2==rd_q3) || (uses_rs2_q2 && rs2_q2==rd_q3)).
  - Effect: pc_en=0, q1q2_en=0, q2q3_bubble=1; q2q3/q3q4/q4q5 enables 1.
  - Lasts exactly one cycle, because the bubble clears mem_ren in q3.
- stall_cycles increments every cycle pc_en=0 (load-use and memory wait) and saturates at all-ones. flush_events also saturates.
- Asynchronous reset mid-stall or mid-flush returns immediately to RUN with counters cleared.

Decomposition:
- Shared package core_pkg holds:
  - FSM state encodings STATE_RUN/STATE_FLUSH/STATE_MEM_WAIT.
  - Opcode constants (OP_LOAD, OP_STORE, OP_BRANCH, ...).
  - CTRL_* bit indices, so the core derives uses_rs*_q2 and mem_ren_q3 consistently.
- One natural sub-module: sat_counter (parameterised width, enable, saturating), instantiated twice.

Test Plan:
1. mem_ren_q3=1, rd_q3=1, rs1_q2=1, uses_rs1_q2=1 -> one cycle with pc_en=0, q1q2_en=0, q2q3_bubble=1. Next cycle (mem_ren_q3=0) all enables 1. stall_cycles=1.
2. Load with rd_q3=0 and rs1_q2=0; separately uses_rs2_q2=0 with rs2 matching -> no stall, stall_cycles=0.
3. branch_taken_q4 one-cycle pulse, FLUSH_CYCLES=1 -> cycle0: pc_sel_branch=1, all three flushes=1. cycle1: state_o=1, q1q2_flush=1 only. cycle2: state_o=0. flush_events=1.
4. dmem_req=1, dmem_ready=0 for 3 cycles then 1 -> all enables 0 for 3 cycles, 1 on the fourth. stall_cycles=3. err_timeout=0.
5. dmem_ready held 0, MEM_TIMEOUT=15 -> enables 0 for cycles 1..14, released on the 15th. err_timeout=1 sticky until rst_n pulse.
6. branch_taken_q4, dmem_req with dmem_ready=0, and a load-use match asserted together -> flushes and pc_sel_branch only: no freeze, no bubble, stall_cycles unchanged. Then assert rst_n low mid-FLUSH -> state_o=0, counters 0.
